// File: rtl/serial_digit_adder_pkg.sv
// Shared types and defaults for the serial digit adder.
// State encoding is fixed so it can be probed from outside.
package serial_digit_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// One digit slice of the iterated carry chain.
// Purely combinational; DIGIT bits plus carry in.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y}
                 + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/sub: DIGIT bits per cycle, LSB first.
// Start/busy/done handshake with held sum, cout, overflow.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N      = WIDTH / DIGIT;
  localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(N - 1);

  state_t state_q;
  state_t state_d;
  logic   load;
  logic   last;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  b_sel;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  res_d;
  logic              carry_q;
  logic [STEP_W-1:0] step_q;
  logic              a_sign_q;
  logic              b_sign_q;
  logic [DIGIT-1:0]  d;
  logic              c;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .cin(carry_q),
    .s  (d),
    .co (c)
  );

  assign b_sel = sub ? ~b : b;

  // New digit enters at the top; after N steps
  // the first digit has reached bit 0.
  assign res_d = (res_q >> DIGIT)
               | (WIDTH'(d) << (WIDTH - DIGIT));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          last    = 1'b1;
        end
      end
      (state_q == IDLE),
      (state_q == DONE): begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      step_q   <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sh     <= a;
      b_sh     <= b_sel;
      carry_q  <= sub;
      step_q   <= '0;
      a_sign_q <= a[WIDTH-1];
      b_sign_q <= b_sel[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> DIGIT;
      b_sh    <= b_sh >> DIGIT;
      res_q   <= res_d;
      carry_q <= c;
      step_q  <= step_q + STEP_W'(1);
      if (last) begin
        sum      <= res_d;
        cout     <= c;
        overflow <= (a_sign_q == b_sign_q)
                 && (res_d[WIDTH-1] != a_sign_q);
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Randomized self-checking bench for serial_digit_adder.
// Reference model uses plain integer arithmetic.
module tb_serial_digit_adder;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         sw_start;
  logic         sw_sub;
  logic [W-1:0] sw_a;
  logic [W-1:0] sw_b;
  logic         sw_busy [3];
  logic         sw_done [3];
  logic         sw_cout [3];
  logic         sw_ovf  [3];
  logic [W-1:0] sw_sum  [3];

  int n_vec = 0;
  int n_bad = 0;

  serial_digit_adder #(
    .WIDTH(W),
    .DIGIT(4)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .overflow(ovf)
  );

  for (genvar j = 0; j < 3; j++) begin : g_sw
    localparam int DG = (j == 0) ? 1 : ((j == 1) ? 8 : 32);
    serial_digit_adder #(
      .WIDTH(W),
      .DIGIT(DG)
    ) u_sw (
      .clk     (clk),
      .reset   (rst),
      .start   (sw_start),
      .sub     (sw_sub),
      .a       (sw_a),
      .b       (sw_b),
      .busy    (sw_busy[j]),
      .done    (sw_done[j]),
      .sum     (sw_sum[j]),
      .cout    (sw_cout[j]),
      .overflow(sw_ovf[j])
    );
  end

  function automatic int dig(input int j);
    return (j == 0) ? 1 : ((j == 1) ? 8 : 32);
  endfunction

  // returns {overflow, cout, sum}
  function automatic logic [W+1:0] ref_op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         s
  );
    longint       sx;
    longint       sy;
    longint       r;
    logic [W:0]   t;
    logic [W-1:0] rs;
    logic         c;
    logic         o;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r  = sx - sy;
      rs = x - y;
      c  = (x >= y);
    end else begin
      r  = sx + sy;
      t  = {1'b0, x} + {1'b0, y};
      rs = t[W-1:0];
      c  = t[W];
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {o, c, rs};
  endfunction

  task automatic run_op(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         s,
    output int           cyc
  );
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    sw_start = 1'b0; sw_sub = 1'b0; sw_a = '0; sw_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    a = 5; b = 3; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_busy cyc%0d: busy=%b done=%b, want 1 0",
                 k, busy, done);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 32'd8
        || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: done=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 00000008 0 0",
               done, busy, sum, cout, ovf);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || sum !== 32'd8) begin
      n_bad++;
      $display("FAIL basic_strobe: done=%b sum=%h, want 0 00000008",
               done, sum);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] xs [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd3, 32'h80000000};
    logic [W-1:0] ys [4] = '{32'd1, 32'd1, 32'd5, 32'd1};
    logic         ss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
    logic         ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ys[i], ss[i], cyc);
      n_vec++;
      if (cyc != 8 || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        n_bad++;
        $display("FAIL directed%0d: cyc=%0d sum=%h cout=%b ovf=%b, want 8 %h %b %b",
                 i, cyc, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_handshake;
    int   cyc;
    logic held_ok;
    a = 10; b = 20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 40) begin
      start = (cyc == 1 || cyc == 4);
      a = start ? 32'd100 : $urandom;
      b = start ? 32'd200 : $urandom;
      sub = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_vec++;
    if (cyc != 8 || sum !== 32'd30) begin
      n_bad++;
      $display("FAIL busy_ignore: cyc=%0d sum=%h, want 8 0000001e",
               cyc, sum);
    end
    a = 7; b = 8; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1 || sum !== 32'd30) begin
      n_bad++;
      $display("FAIL done_restart: done=%b busy=%b sum=%h, want 0 1 0000001e",
               done, busy, sum);
    end
    cyc = 1;
    held_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (sum !== 32'd30) held_ok = 1'b0;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc != 9 || !held_ok || sum !== 32'd15) begin
      n_bad++;
      $display("FAIL back_to_back: cyc=%0d held=%b sum=%h, want 9 1 0000000f",
               cyc, held_ok, sum);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_strobe: done=%b, want 0", done);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    a = 32'h12345678; b = 32'h0F0F0F0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_midrun: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd1, 32'd1, 1'b0, cyc);
    n_vec++;
    if (cyc != 8 || sum !== 32'd2 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: cyc=%0d sum=%h cout=%b ovf=%b, want 8 00000002 0 0",
               cyc, sum, cout, ovf);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W+1:0] e;
    int           cyc;
    for (int i = 0; i < 200; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom);
      e = ref_op(x, y, s);
      run_op(x, y, s, cyc);
      n_vec++;
      if (cyc != 8 || {ovf, cout, sum} !== e) begin
        n_bad++;
        $display("FAIL random%0d: %h %s %h cyc=%0d got o/c/s=%b/%b/%h want 8 %b/%b/%h",
                 i, x, s ? "-" : "+", y, cyc, ovf, cout, sum,
                 e[W+1], e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W+1:0] e;
    int           got [3];
    for (int i = 0; i < 1000; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom);
      if (i % 50 == 0) begin
        x = 32'h80000000;
        y = (i % 100 == 0) ? 32'h80000000 : 32'h7FFFFFFF;
      end
      e = ref_op(x, y, s);
      sw_a = x; sw_b = y; sw_sub = s; sw_start = 1'b1;
      @(posedge clk); #1;
      sw_start = 1'b0;
      sw_a = $urandom; sw_b = $urandom; sw_sub = 1'($urandom);
      for (int j = 0; j < 3; j++) got[j] = 0;
      for (int c = 1; c <= 34; c++) begin
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
          if (sw_done[j] && got[j] == 0) begin
            got[j] = c;
            n_vec++;
            if ({sw_ovf[j], sw_cout[j], sw_sum[j]} !== e) begin
              n_bad++;
              $display("FAIL sweep_d%0d op%0d: %h %s %h got o/c/s=%b/%b/%h want %b/%b/%h",
                       dig(j), i, x, s ? "-" : "+", y,
                       sw_ovf[j], sw_cout[j], sw_sum[j],
                       e[W+1], e[W], e[W-1:0]);
            end
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        n_vec++;
        if (got[j] != W / dig(j)) begin
          n_bad++;
          $display("FAIL sweep_lat_d%0d op%0d: done at %0d, want %0d",
                   dig(j), i, got[j], W / dig(j));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_handshake();
    test_reset_midrun();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Multi-cycle adder/subtractor for the adder datapath. Processes two WIDTH-bit operands DIGIT bits per cycle, LSB first, one carry flip-flop between digits.
- Produces sum, carry-out and signed overflow with a start/busy/done handshake.
- Feeds the downstream register stage with a one-cycle done strobe and held result. Replaces a wide combinational carry chain with a narrow iterated one.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits added per cycle. WIDTH must be an integer multiple of DIGIT.
- N (localparam), WIDTH/DIGIT, number of digit steps.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b. Sampled with start.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle strobe: result valid.
- sum  output  WIDTH  result. Held until the next completion.
- cout  output  1  final carry. For subtraction, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, carry and step counter cleared.
  - The in-flight operation is discarded, with no partial result.
- States: IDLE, RUN, DONE. Registered Moore outputs; busy=1 exactly in RUN, done=1 exactly in DONE.
- IDLE or DONE, start=1 at an edge:
  - Latch A_sh=a, B_sh=(sub ? ~b : b), carry=sub, step=0, and the sign bits a[WIDTH-1] and b'[WIDTH-1].
  - Go to RUN.
- IDLE or DONE, start=0: DONE goes to IDLE; IDLE stays.
- RUN, each edge:
  - {c, d} = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + carry.
  - d is shifted into the result shift register from the MSB side. A_sh and B_sh shift right by DIGIT. carry=c, step=step+1.
  - On the edge where step reaches N-1 (the N-th digit), go to DONE. On that same edge, load sum=completed result, cout=c, overflow.
- overflow = (a_sign == b'_sign) && (result[WIDTH-1] != a_sign), using the inverted b for sub.
- Latency: start edge at t0 gives done=1 during the cycle after edge t0+N. For WIDTH=32, DIGIT=4 this is 8 cycles. Throughput is one operation per N+1 cycles back-to-back.
- start while busy=1 is ignored. Operands and sub may change freely during RUN.
- start during the DONE cycle is accepted: next state RUN, done drops after one cycle, and sum stays valid until the next completion.
- sum, cout and overflow change only on the edge entering DONE, or on reset.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package/header:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH and DIGIT.
- One combinational sub-module, digit_adder: DIGIT-bit inputs x, y, cin; outputs s[DIGIT-1:0], co. Instantiated once.
- FSM, shift registers, counter and output registers live in serial_digit_adder.

Test Plan (WIDTH=32, DIGIT=4 unless stated):
1. a=5, b=3, sub=0, start for 1 cycle -> busy for 8 cycles, then done=1 for exactly 1 cycle; sum=0x00000008, cout=0, overflow=0.
2. a=0xFFFFFFFF, b=0x00000001, add -> sum=0x00000000, cout=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, overflow=1.
3. Subtraction:
   - a=3, b=5, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0.
   - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
4. Handshake:
   - start op1 (10+20). Pulse start with op2 (100+200) at cycles 2 and 5 of RUN -> ignored; done shows sum=30.
   - Assert start with 7+8 during the DONE cycle -> accepted; second done after 9 cycles with sum=15. The first sum is held in between.
5. Reset mid-operation: assert reset between clock edges at RUN step 3 -> immediately busy=0, done=0, sum=0, cout=0, overflow=0. After release, 1+1 completes in 8 cycles with sum=2.
6. Parameter sweep: DIGIT=1, 8, 32 with 1000 random a/b/sub -> done exactly N cycles after start; sum, cout and overflow match the reference model a+b or a+~b+1.
